// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: NUM_FIELDS two-digit BCD countdown fields with an IDLE/RUN/PAUSED/DONE FSM.
// Optional macro AUTO_RELOAD_EN: on expiry in RUN, reload the last valid load and keep running.
module bcd_countdown_timer #(
    parameter int NUM_FIELDS   = 2,
    parameter int TOP_TENS_MAX = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wrtEn,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    decEn,
    input  logic [8*NUM_FIELDS-1:0] timeIn,
    output logic [8*NUM_FIELDS-1:0] timeOut,
    output logic                    running,
    output logic                    done,
    output logic                    expired,
    output logic                    loadErr,
    output logic [1:0]              state_o
);

    localparam int W = 8 * NUM_FIELDS;
    localparam logic [3:0] TOP_T = TOP_TENS_MAX[3:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Control inputs are single-cycle level strobes sampled on posedge clk; there is no valid/ready
    // handshake, a strobe is consumed in the cycle it is seen or dropped.
    state_t       state_q;
    logic [W-1:0] count_q;
    logic [W-1:0] dec_d;
    logic         expired_q;
    logic         load_err_q;
    logic         load_ok;
    logic         borrow;
    logic [3:0]   ones;
    logic [3:0]   tens;
    logic [3:0]   tens_max;
    logic         count_zero;
    logic         dec_zero;

`ifdef AUTO_RELOAD_EN
    logic [W-1:0] shadow_q;
`endif

    // Digit-wise borrow ripple keeps every digit inside its BCD/base-60 range.
    always_comb begin
        dec_d    = count_q;
        load_ok  = 1'b1;
        borrow   = 1'b1;
        ones     = 4'd0;
        tens     = 4'd0;
        tens_max = 4'd5;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            tens_max = (f == NUM_FIELDS - 1) ? TOP_T : 4'd5;
            ones     = count_q[8*f +: 4];
            tens     = count_q[8*f+4 +: 4];
            if (borrow) begin
                if (ones == 4'd0) begin
                    dec_d[8*f +: 4] = 4'd9;
                end else begin
                    dec_d[8*f +: 4] = ones - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (borrow) begin
                if (tens == 4'd0) begin
                    dec_d[8*f+4 +: 4] = tens_max;
                end else begin
                    dec_d[8*f+4 +: 4] = tens - 4'd1;
                    borrow = 1'b0;
                end
            end
            if ((timeIn[8*f +: 4] > 4'd9) || (timeIn[8*f+4 +: 4] > tens_max)) begin
                load_ok = 1'b0;
            end
        end
    end

    assign count_zero = (count_q == '0);
    assign dec_zero   = (dec_d == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            state_q    <= S_IDLE;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
            shadow_q   <= '0;
`endif
        end else begin
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
            if (wrtEn) begin
                if (load_ok) begin
                    count_q <= timeIn;
                    state_q <= S_IDLE;
`ifdef AUTO_RELOAD_EN
                    shadow_q <= timeIn;
`endif
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (pause && (state_q == S_RUN)) begin
                state_q <= S_PAUSED;
            end else if (start && ((state_q == S_IDLE) || (state_q == S_PAUSED))) begin
                if (count_zero) begin
                    state_q   <= S_DONE;
                    expired_q <= 1'b1;
                end else begin
                    state_q <= S_RUN;
                end
            end else if (decEn && (state_q == S_RUN)) begin
                // start has no effect in RUN, so it does not mask a tick here.
                if (count_zero || dec_zero) begin
                    expired_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (shadow_q != '0) begin
                        count_q <= shadow_q;
                    end else begin
                        count_q <= '0;
                        state_q <= S_DONE;
                    end
`else
                    count_q <= '0;
                    state_q <= S_DONE;
`endif
                end else begin
                    count_q <= dec_d;
                end
            end
        end
    end

    assign timeOut = count_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign expired = expired_q;
    assign loadErr = load_err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: a 2-field and a 3-field instance share controls.
// Build with +define+AUTO_RELOAD_EN to exercise the reload path instead of the plain expiry path.
module tb_bcd_countdown_timer;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrtEn = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        decEn = 1'b0;
    logic [23:0] tin = '0;

    logic [15:0] to2;
    logic        run2, dn2, ex2, le2;
    logic [1:0]  st2;
    logic [23:0] to3;
    logic        run3, dn3, ex3, le3;
    logic [1:0]  st3;

    typedef struct {
        logic        sel;
        logic [23:0] t;
        logic [1:0]  st;
        logic        ex;
        logic        le;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_FIELDS(2), .TOP_TENS_MAX(9)) dut2 (
        .clk(clk), .reset(reset), .wrtEn(wrtEn), .start(start), .pause(pause), .decEn(decEn),
        .timeIn(tin[15:0]), .timeOut(to2), .running(run2), .done(dn2), .expired(ex2),
        .loadErr(le2), .state_o(st2)
    );

    bcd_countdown_timer #(.NUM_FIELDS(3), .TOP_TENS_MAX(9)) dut3 (
        .clk(clk), .reset(reset), .wrtEn(wrtEn), .start(start), .pause(pause), .decEn(decEn),
        .timeIn(tin), .timeOut(to3), .running(run3), .done(dn3), .expired(ex3),
        .loadErr(le3), .state_o(st3)
    );

    // Driver: apply one cycle of inputs, return just after the sampling edge.
    task automatic tick(input logic r, input logic w, input logic s, input logic p,
                        input logic d, input logic [23:0] v);
        reset = r; wrtEn = w; start = s; pause = p; decEn = d; tin = v;
        @(posedge clk);
        #1;
        reset = 1'b0; wrtEn = 1'b0; start = 1'b0; pause = 1'b0; decEn = 1'b0;
    endtask

    task automatic expect_o(input logic sel, input logic [23:0] t, input logic [1:0] st,
                            input logic ex, input logic le, input string name);
        exp_t e;
        e.sel = sel; e.t = t; e.st = st; e.ex = ex; e.le = le; e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: every negedge with a pending expectation, compare the selected instance.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [29:0] got, want;
            e = exp_q.pop_front();
            if (e.sel)
                got = {to3, st3, run3, dn3, ex3, le3};
            else
                got = {8'h00, to2, st2, run2, dn2, ex2, le2};
            want = {e.t, e.st, (e.st == S_RUN), (e.st == S_DONE), e.ex, e.le};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got t=%h st=%0d run=%b done=%b exp=%b lerr=%b, want t=%h st=%0d run=%b done=%b exp=%b lerr=%b",
                         e.name, got[29:6], got[5:4], got[3], got[2], got[1], got[0],
                         want[29:6], want[5:4], want[3], want[2], want[1], want[0]);
            end
        end
    end

    initial begin
        // Reset state
        tick(1, 0, 0, 0, 0, 24'h0);
        expect_o(0, 24'h0, S_IDLE, 0, 0, "reset2");
        tick(0, 0, 0, 0, 0, 24'h0);
        expect_o(1, 24'h0, S_IDLE, 0, 0, "reset3");

`ifndef AUTO_RELOAD_EN
        // Full minute countdown to zero
        tick(0, 1, 0, 0, 0, 24'h0100);
        expect_o(0, 24'h0100, S_IDLE, 0, 0, "t1_load");
        tick(0, 0, 1, 0, 0, 24'h0);
        expect_o(0, 24'h0100, S_RUN, 0, 0, "t1_start");
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0059, S_RUN, 0, 0, "t1_first_dec");
        for (int i = 0; i < 58; i++) tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0000, S_DONE, 1, 0, "t1_expire");
        tick(0, 0, 0, 0, 0, 24'h0);
        expect_o(0, 24'h0000, S_DONE, 0, 0, "t1_expire_one_cycle");
        tick(0, 0, 1, 0, 1, 24'h0);
        expect_o(0, 24'h0000, S_DONE, 0, 0, "t1_done_holds");
`endif

        // Top-field borrow across both fields
        tick(0, 1, 0, 0, 0, 24'h1000);
        expect_o(0, 24'h1000, S_IDLE, 0, 0, "top_load");
        tick(0, 0, 1, 0, 1, 24'h0);
        expect_o(0, 24'h1000, S_RUN, 0, 0, "start_ignores_dec");
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0959, S_RUN, 0, 0, "top_borrow");

        // Pause / resume
        tick(1, 0, 0, 0, 0, 24'h0);
        tick(0, 1, 0, 0, 0, 24'h0010);
        tick(0, 0, 1, 0, 0, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0007, S_RUN, 0, 0, "t3_three_dec");
        tick(0, 0, 0, 1, 0, 24'h0);
        expect_o(0, 24'h0007, S_PAUSED, 0, 0, "t3_pause");
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0007, S_PAUSED, 0, 0, "t3_paused_holds");
        tick(0, 0, 1, 0, 0, 24'h0);
        expect_o(0, 24'h0007, S_RUN, 0, 0, "t3_resume");
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0006, S_RUN, 0, 0, "t3_dec_after_resume");
        tick(0, 0, 1, 1, 1, 24'h0);
        expect_o(0, 24'h0006, S_PAUSED, 0, 0, "pause_wins_in_run");
        tick(0, 0, 1, 1, 1, 24'h0);
        expect_o(0, 24'h0006, S_RUN, 0, 0, "start_wins_in_paused");

        // Zero load then start
        tick(0, 1, 0, 0, 0, 24'h0000);
        expect_o(0, 24'h0000, S_IDLE, 0, 0, "t4_load_zero");
        tick(0, 0, 1, 0, 0, 24'h0);
        expect_o(0, 24'h0000, S_DONE, 1, 0, "t4_start_zero");
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0000, S_DONE, 0, 0, "t4_dec_in_done");
        tick(0, 1, 0, 0, 0, 24'h0100);
        expect_o(0, 24'h0100, S_IDLE, 0, 0, "load_from_done");

        // Reset and loads in RUN
        tick(0, 1, 0, 0, 0, 24'h0030);
        tick(0, 0, 1, 0, 0, 24'h0);
        expect_o(0, 24'h0030, S_RUN, 0, 0, "t5_run");
        tick(1, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0000, S_IDLE, 0, 0, "t5_reset_in_run");
        tick(0, 1, 0, 0, 0, 24'h0030);
        tick(0, 0, 1, 0, 0, 24'h0);
        tick(0, 1, 0, 0, 1, 24'h0075);
        expect_o(0, 24'h0030, S_RUN, 0, 1, "bad_sec_tens");
        tick(0, 0, 0, 0, 0, 24'h0);
        expect_o(0, 24'h0030, S_RUN, 0, 0, "loaderr_one_cycle");
        tick(0, 1, 0, 0, 0, 24'h000A);
        expect_o(0, 24'h0030, S_RUN, 0, 1, "bad_ones");
        tick(0, 1, 0, 0, 1, 24'h0100);
        expect_o(0, 24'h0100, S_IDLE, 0, 0, "t5_load_aborts_run");
        tick(0, 1, 0, 0, 0, 24'h9959);
        expect_o(0, 24'h9959, S_IDLE, 0, 0, "top_tens_9_ok");

`ifdef AUTO_RELOAD_EN
        tick(0, 1, 0, 0, 0, 24'h0003);
        tick(0, 0, 1, 0, 0, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0003, S_RUN, 1, 0, "t6_reload");
        tick(0, 0, 0, 0, 0, 24'h0);
        expect_o(0, 24'h0003, S_RUN, 0, 0, "t6_pulse_one_cycle");
        tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(0, 24'h0003, S_RUN, 1, 0, "t6_second_reload");
`endif

        // Three-field instance
        tick(1, 0, 0, 0, 0, 24'h0);
        tick(0, 1, 0, 0, 0, 24'h100000);
        expect_o(1, 24'h100000, S_IDLE, 0, 0, "t2_load");
        tick(0, 0, 1, 0, 0, 24'h0);
        tick(0, 0, 0, 0, 1, 24'h0);
        expect_o(1, 24'h095959, S_RUN, 0, 0, "t2_dec");
        tick(0, 1, 0, 0, 0, 24'h006000);
        expect_o(1, 24'h095959, S_RUN, 0, 1, "t2_bad_min_tens");
        tick(0, 1, 0, 0, 0, 24'h0A0000);
        expect_o(1, 24'h095959, S_RUN, 0, 1, "t2_bad_hour_ones");
        tick(0, 1, 0, 0, 0, 24'h995959);
        expect_o(1, 24'h995959, S_IDLE, 0, 0, "t2_max_load");

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
